// File: rtl/stream_arb_4_1.sv
// stream_arb_4_1
// Four-channel valid/ready stream arbiter with round-robin priority and a
// single registered output stage.
//
// Each cycle the arbiter picks one valid input channel, starting the search
// at the round-robin pointer. The winning word is captured into the output
// register whenever that register is empty or being drained in the same
// cycle. This sustains one word per cycle with no bubble.
//
// Ports
//   clk        sole clock, all state updates on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   per-channel valid (bit i = channel i)
//   in_data0-3 per-channel data, WIDTH bits each
//   in_ready   per-channel ready, at most one bit high per cycle
//   out_valid  output register holds a word
//   out_ready  downstream accepts the word this cycle
//   out_data   registered winning word
//   out_id     index of the channel that supplied out_data
//   out_sel    combinational grant index this cycle (0 when idle), for an
//              external 4:1 data mux
module stream_arb_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_id,
  output logic [1:0]       out_sel
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [1:0]       out_id_q,    out_id_d;
  logic [1:0]       ptr_q,       ptr_d;

  logic             load_en;
  logic             any_valid;
  logic [1:0]       winner;
  logic [1:0]       idx;
  logic [WIDTH-1:0] win_data;

  // The output register can take a new word when it is empty or being
  // drained this cycle.
  assign load_en = !out_valid_q || out_ready;

  // Search the channels in order ptr, ptr+1, ptr+2, ptr+3. The 2-bit add
  // wraps naturally, so the search rotates without an explicit modulo.
  always_comb begin
    any_valid = 1'b0;
    winner    = 2'd0;
    idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!any_valid && in_valid[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

  // Internal copy of the data mux that out_sel drives externally.
  always_comb begin
    win_data = in_data0;
    case (winner)
      2'd0: win_data = in_data0;
      2'd1: win_data = in_data1;
      2'd2: win_data = in_data2;
      2'd3: win_data = in_data3;
      default: win_data = in_data0;
    endcase
  end

  // Grant the winner only when a load can happen. Reset blocks every grant
  // so that no upstream word is consumed while it would be discarded.
  always_comb begin
    in_ready = 4'b0000;
    if (load_en && any_valid && !rst) begin
      in_ready = 4'b0001 << winner;
    end
  end

  assign out_sel = winner;

  // On a load, capture the winner and move the pointer just past it. On an
  // idle load the register empties, but data, id and pointer keep their
  // last values. On a stall, everything holds.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (any_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = win_data;
        out_id_d    = winner;
        ptr_d       = winner + 2'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= 2'd0;
      ptr_q       <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_stream_arb_4_1.sv
// Testbench for stream_arb_4_1: reference model plus scoreboard of accepted words.
module tb_stream_arb_4_1;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_id;
  logic [1:0]       out_sel;

  stream_arb_4_1 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data0 (in_data0),
    .in_data1 (in_data1),
    .in_data2 (in_data2),
    .in_data3 (in_data3),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_id   (out_id),
    .out_sel  (out_sel)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;

  // Scoreboard entries are {channel id, data word}.
  logic [WIDTH+1:0] scoreQ[$];

  // Reference model state.
  int               mPtr;
  logic             mValid;
  logic [WIDTH-1:0] mData;
  logic [1:0]       mId;
  logic [WIDTH-1:0] chData[4];

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic setData(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                         input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
    chData[0] = d0; chData[1] = d1; chData[2] = d2; chData[3] = d3;
    in_data0 = d0; in_data1 = d1; in_data2 = d2; in_data3 = d3;
  endtask

  // Drive one cycle starting just after a falling edge. Check the
  // combinational grant and the output side against the model. Record
  // accepted words, then advance to the next falling edge.
  task automatic applyStimulus(input logic [3:0] v, input logic ordy);
    logic            mLoad;
    logic            found;
    logic [1:0]      win;
    logic [3:0]      expReady;
    logic [WIDTH+1:0] entry;
    int              c;
    in_valid  = v;
    out_ready = ordy;
    #1;
    mLoad = !mValid || ordy;
    found = 1'b0;
    win   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      c = (mPtr + k) % 4;
      if (!found && v[c]) begin
        found = 1'b1;
        win   = 2'(c);
      end
    end
    expReady = 4'b0000;
    if (mLoad && found) expReady[win] = 1'b1;
    checkOutput("in_ready", 32'(in_ready), 32'(expReady));
    checkOutput("out_sel", 32'(out_sel), 32'(win));
    checkOutput("out_valid", 32'(out_valid), 32'(mValid));
    if (mValid) begin
      checkOutput("out_data_model", 32'(out_data), 32'(mData));
      checkOutput("out_id_model", 32'(out_id), 32'(mId));
    end
    if (out_valid && out_ready) begin
      if (scoreQ.size() == 0) begin
        checkOutput("sb_unexpected_word", 32'(1), 32'(0));
      end else begin
        entry = scoreQ.pop_front();
        checkOutput("sb_data", 32'(out_data), 32'(entry[WIDTH-1:0]));
        checkOutput("sb_id", 32'(out_id), 32'(entry[WIDTH+1:WIDTH]));
      end
    end
    if (mLoad && found) scoreQ.push_back({win, chData[win]});
    if (mLoad) begin
      if (found) begin
        mValid = 1'b1;
        mData  = chData[win];
        mId    = win;
        mPtr   = (int'(win) + 1) % 4;
      end else begin
        mValid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset for n cycles with the given valids. Ready must stay low the
  // whole time, and the output must come out cleared.
  task automatic applyReset(input int n, input logic [3:0] v);
    rst       = 1'b1;
    in_valid  = v;
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      checkOutput("rst_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
      checkOutput("rst_out_data", 32'(out_data), 32'(0));
      checkOutput("rst_out_id", 32'(out_id), 32'(0));
    end
    rst = 1'b0;
    scoreQ.delete();
    mPtr   = 0;
    mValid = 1'b0;
    mData  = '0;
    mId    = 2'd0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 4'b0000;
    out_ready = 1'b0;
    setData(4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);

    // Reset with nothing valid.
    applyReset(3, 4'b0000);

    // All channels valid, downstream always ready: ids rotate 0..3.
    setData(4'hA, 4'hB, 4'hC, 4'hD);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, 1'b1);
      checkOutput("rr_valid", 32'(out_valid), 32'(1));
      checkOutput("rr_id", 32'(out_id), 32'(i % 4));
      checkOutput("rr_data", 32'(out_data), 32'(4'hA + 4'(i % 4)));
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput("drain_valid", 32'(out_valid), 32'(0));

    // Move the pointer to 3, then offer only channel 2.
    setData(4'h1, 4'h2, 4'h3, 4'h4);
    applyStimulus(4'b0100, 1'b1);
    setData(4'h0, 4'h0, 4'h5, 4'h0);
    #1;
    in_valid = 4'b0100;
    out_ready = 1'b1;
    #1;
    checkOutput("ch2_ready", 32'(in_ready), 32'(4'b0100));
    applyStimulus(4'b0100, 1'b1);
    checkOutput("ch2_id", 32'(out_id), 32'(2));
    checkOutput("ch2_data", 32'(out_data), 32'(5));

    // Pointer is 3. Load 0x7 from channel 1 alone, then stall for three cycles.
    setData(4'h1, 4'h7, 4'h9, 4'h3);
    applyStimulus(4'b0010, 1'b1);
    checkOutput("hold_load_id", 32'(out_id), 32'(1));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1111, 1'b0);
      checkOutput("hold_data", 32'(out_data), 32'(7));
      checkOutput("hold_id", 32'(out_id), 32'(1));
    end
    applyStimulus(4'b1111, 1'b1);
    checkOutput("after_stall_id", 32'(out_id), 32'(2));
    checkOutput("after_stall_data", 32'(out_data), 32'(9));
    applyStimulus(4'b0000, 1'b1);

    // Pointer is 3. Load channel 0 alone so the pointer becomes 1. Then
    // valids 1001 must grant channel 3 and wrap back to channel 0.
    setData(4'h6, 4'h0, 4'h0, 4'hE);
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b1001, 1'b1);
    checkOutput("wrap_first", 32'(out_id), 32'(3));
    applyStimulus(4'b1001, 1'b1);
    checkOutput("wrap_second", 32'(out_id), 32'(0));
    applyStimulus(4'b0000, 1'b1);

    // Random traffic with backpressure.
    for (int i = 0; i < 300; i++) begin
      setData(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      applyStimulus(4'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    // Reset while a word is stalled: the word is discarded.
    setData(4'h8, 4'h9, 4'hA, 4'hB);
    applyStimulus(4'b0100, 1'b1);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("pre_rst_valid", 32'(out_valid), 32'(1));
    applyReset(1, 4'b1111);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("post_rst_id", 32'(out_id), 32'(0));
    checkOutput("post_rst_data", 32'(out_data), 32'(8));

    // Drain and confirm no word went missing.
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("sb_drained", 32'(scoreQ.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/stream_arb_4_1.md
STREAM_ARB_4_1 -- requirements
Module: stream_arb_4_1

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, data width of every channel.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port: in_valid  input  4  per-channel valid, bit i = channel i.
REQ-005 SHALL have ports: in_data0..in_data3  input  WIDTH each  channel data.
REQ-006 SHALL have port: in_ready  output  4  per-channel ready, bit i = channel i.
REQ-007 SHALL have port: out_valid  output  1  registered output holds a word.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts word.
REQ-009 SHALL have port: out_data  output  WIDTH  registered winning word.
REQ-010 SHALL have port: out_id  output  2  index of channel that supplied out_data.
REQ-011 SHALL have port: out_sel  output  2  combinational grant index this cycle, for an external 4:1 data mux.

Function
REQ-012 Transfer on a channel SHALL occur iff in_valid[i] && in_ready[i] at a rising edge; output transfer iff out_valid && out_ready.
REQ-013 load_en SHALL be (!out_valid || out_ready); no other condition gates a load.
REQ-014 Round-robin pointer ptr (2 bits) SHALL define priority order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-015 Winner SHALL be the first channel in priority order with in_valid set; out_sel = winner index, 0 when no in_valid set.
REQ-016 in_ready[i] SHALL be 1 iff load_en && any in_valid && i == winner; at most one in_ready bit high per cycle.
REQ-017 in_ready SHALL be 4'b0000 when no channel is valid, and SHALL not depend on in_valid of the winner combinationally beyond REQ-015.
REQ-018 On a load, next cycle: out_valid=1, out_data=in_data[winner], out_id=winner, ptr=(winner+1) mod 4 (wrap 3->0).
REQ-019 When load_en and no in_valid: out_valid SHALL become 0 next cycle; out_data, out_id, ptr hold.
REQ-020 When out_valid && !out_ready: out_valid, out_data, out_id, ptr SHALL hold unchanged (stall); in_ready=0.
REQ-021 Simultaneous output accept and new input SHALL load the new word in the same cycle (1 word/cycle sustained, no bubble).
REQ-022 Latency SHALL be exactly 1 cycle from input transfer to out_valid.
REQ-023 ptr SHALL advance only on a load; never on stalls or idle cycles.
REQ-024 Words SHALL never be duplicated or dropped; each accepted word appears on output exactly once.

Reset
REQ-025 While rst=1 at a rising edge: out_valid=0, out_data=0, out_id=0, ptr=0; in_ready SHALL be 0 in any cycle where rst=1.
REQ-026 Reset asserted mid-stall SHALL discard the held word; first load after reset SHALL use ptr=0 priority.

Verification
REQ-027 Reset, all in_valid=0 -> out_valid=0, out_data=0, out_id=0, in_ready=0000 each cycle.
REQ-028 in_valid=1111, data 0xA,0xB,0xC,0xD, out_ready=1, 8 cycles -> out_id 0,1,2,3,0,1,2,3, out_data A,B,C,D repeating, out_valid continuously 1 from cycle 1.
REQ-029 Only channel 2 valid (data 0x5) after ptr=3 -> in_ready=0100, out_id=2, out_data=0x5 next cycle; ptr becomes 3.
REQ-030 Word 0x7 from ch1 held with out_ready=0 for 3 cycles while in_valid=1111 -> out_data=0x7, out_id=1 stable, in_ready=0000; on out_ready=1, ch2 loaded next cycle.
REQ-031 in_valid=1001 with ptr=1 -> ch3 granted first, then ch0 (ptr wrap 3->0 verified).
REQ-032 rst pulsed while out_valid=1 stalled -> next cycle out_valid=0; with in_valid=1111 afterwards, first out_id=0.
